data_cache: RTL

Direct-mapped, write-back, write-allocate data cache between the CPU load/store stage and `data_mem`. It serves word-wide CPU reads and writes in a single cycle on a hit. On a miss it stalls the CPU with `cpu_busy_wait`, writes back a dirty victim block if needed, and refills the block through `data_mem`'s multi-cycle busy-wait handshake. Capacity is 8 lines × 2 words × 16 bits, covering the 7-bit word address space.

---
 rtl/data_cache_pkg.sv | 21 ++
 rtl/data_cache_store.sv | 57 +++++
 rtl/data_cache.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/data_cache_pkg.sv
// Shared types and widths for the direct-mapped write-back data cache.
package data_cache_pkg;

  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 1;
  localparam int WORD_W   = 16;
  localparam int ADDR_W   = 7;

  // Miss-handling FSM. GAP drops both mem requests for one cycle so the
  // memory sees a fresh request edge for every word.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WB_REQ     = 3'd1,
    WB_WAIT    = 3'd2,
    GAP        = 3'd3,
    FETCH_REQ  = 3'd4,
    FETCH_WAIT = 3'd5
  } cache_state_t;

endpackage

// File: rtl/data_cache_store.sv
// Line storage: valid/dirty bits (async clear) plus tag and data arrays.
// One combinational whole-line read port, one synchronous write port that
// can update a single data word and/or the line metadata.
module data_cache_store
  import data_cache_pkg::*;
#(
  parameter int LINES = 8,
  parameter int WORDS = 2,
  parameter int TW    = 3,
  parameter int IW    = $clog2(LINES),
  parameter int OW    = $clog2(WORDS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IW-1:0]                rd_index,
  output logic                         rd_valid,
  output logic                         rd_dirty,
  output logic [TW-1:0]                rd_tag,
  output logic [WORDS-1:0][WORD_W-1:0] rd_data,
  input  logic                         we_data,
  input  logic                         we_meta,
  input  logic [IW-1:0]                wr_index,
  input  logic [OW-1:0]                wr_offset,
  input  logic [WORD_W-1:0]            wr_data,
  input  logic                         wr_valid,
  input  logic                         wr_dirty,
  input  logic [TW-1:0]                wr_tag
);

  logic [LINES-1:0]              valid_q;
  logic [LINES-1:0]              dirty_q;
  logic [TW-1:0]                 tag_q  [LINES];
  logic [WORDS-1:0][WORD_W-1:0]  data_q [LINES];

  // Status bits: cleared asynchronously so reset invalidates every line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_meta) begin
      valid_q[wr_index] <= wr_valid;
      dirty_q[wr_index] <= wr_dirty;
    end
  end

  // Tag and data contents carry no reset; they are meaningless until valid.
  always_ff @(posedge clk) begin
    if (we_meta) tag_q[wr_index] <= wr_tag;
    if (we_data) data_q[wr_index][wr_offset] <= wr_data;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache.
// CPU side: a request is cpu_read ^ cpu_write; cpu_busy_wait high means the
// request has not completed and the CPU must hold address/data/request.
// A request completes at the first posedge where cpu_busy_wait is low.
// Memory side: mem_read/mem_write are levels held until the first posedge
// with mem_busy_wait low; a one-cycle gap separates successive words.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int LINES = 8,
  parameter int WORDS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic [ADDR_W-1:0]   cpu_address,
  input  logic [WORD_W-1:0]   cpu_write_data,
  output logic [WORD_W-1:0]   cpu_read_data,
  output logic                cpu_busy_wait,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [WORD_W-1:0]   mem_write_data,
  input  logic [WORD_W-1:0]   mem_read_data,
  input  logic                mem_busy_wait,
  output logic [2:0]          dbg_state
);

  localparam int IW = $clog2(LINES);
  localparam int OW = $clog2(WORDS);
  localparam int TW = ADDR_W - IW - OW;

  cache_state_t state;
  logic [OW-1:0] word_cnt;
  logic [TW-1:0] lat_tag;
  logic [IW-1:0] lat_index;
  logic          gap_to_fetch;

  logic [TW-1:0] cpu_tag;
  logic [IW-1:0] cpu_index;
  logic [OW-1:0] cpu_offset;
  logic          req, hit, read_hit, write_hit, last_word;

  logic [IW-1:0]               st_rd_index;
  logic                        st_valid, st_dirty;
  logic [TW-1:0]               st_tag;
  logic [WORDS-1:0][WORD_W-1:0] st_data;
  logic                        st_we_data, st_we_meta;
  logic [IW-1:0]               st_wr_index;
  logic [OW-1:0]               st_wr_offset;
  logic [WORD_W-1:0]           st_wr_data;
  logic                        st_wr_valid, st_wr_dirty;
  logic [TW-1:0]               st_wr_tag;

  assign cpu_tag    = cpu_address[ADDR_W-1 -: TW];
  assign cpu_index  = cpu_address[OW +: IW];
  assign cpu_offset = cpu_address[OW-1:0];

  // While a miss is in flight only the latched index addresses the store.
  assign st_rd_index = (state == IDLE) ? cpu_index : lat_index;

  assign req       = cpu_read ^ cpu_write;
  assign hit       = st_valid && (st_tag == cpu_tag);
  assign read_hit  = (state == IDLE) && cpu_read && !cpu_write && hit;
  assign write_hit = (state == IDLE) && cpu_write && !cpu_read && hit && !mem_busy_wait;
  assign last_word = (word_cnt == OW'(WORDS - 1));

  assign cpu_read_data = read_hit ? st_data[cpu_offset] : '0;
  assign cpu_busy_wait = (state != IDLE) || (req && (!hit || mem_busy_wait));
  assign dbg_state     = state;

  data_cache_store #(
    .LINES(LINES), .WORDS(WORDS), .TW(TW), .IW(IW), .OW(OW)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (st_rd_index),
    .rd_valid  (st_valid),
    .rd_dirty  (st_dirty),
    .rd_tag    (st_tag),
    .rd_data   (st_data),
    .we_data   (st_we_data),
    .we_meta   (st_we_meta),
    .wr_index  (st_wr_index),
    .wr_offset (st_wr_offset),
    .wr_data   (st_wr_data),
    .wr_valid  (st_wr_valid),
    .wr_dirty  (st_wr_dirty),
    .wr_tag    (st_wr_tag)
  );

  // Store write port: CPU write hits in IDLE, refill words in FETCH_WAIT.
  always_comb begin
    st_we_data   = 1'b0;
    st_we_meta   = 1'b0;
    st_wr_index  = cpu_index;
    st_wr_offset = cpu_offset;
    st_wr_data   = cpu_write_data;
    st_wr_valid  = 1'b1;
    st_wr_dirty  = 1'b1;
    st_wr_tag    = cpu_tag;
    if (write_hit) begin
      st_we_data = 1'b1;
      st_we_meta = 1'b1;
    end else if (state == FETCH_WAIT && !mem_busy_wait) begin
      st_we_data   = 1'b1;
      st_we_meta   = last_word;
      st_wr_index  = lat_index;
      st_wr_offset = word_cnt;
      st_wr_data   = mem_read_data;
      st_wr_dirty  = 1'b0;
      st_wr_tag    = lat_tag;
    end
  end

  // Miss FSM; every mem output is a register updated on state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      word_cnt       <= '0;
      lat_tag        <= '0;
      lat_index      <= '0;
      gap_to_fetch   <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          word_cnt <= '0;
          if (req && !hit && !mem_busy_wait) begin
            lat_tag   <= cpu_tag;
            lat_index <= cpu_index;
            if (st_valid && st_dirty) begin
              state          <= WB_REQ;
              mem_write      <= 1'b1;
              mem_address    <= {st_tag, cpu_index, OW'(0)};
              mem_write_data <= st_data[0];
            end else begin
              state       <= FETCH_REQ;
              mem_read    <= 1'b1;
              mem_address <= {cpu_tag, cpu_index, OW'(0)};
            end
          end
        end
        WB_REQ: state <= WB_WAIT;
        WB_WAIT: begin
          if (!mem_busy_wait) begin
            mem_write    <= 1'b0;
            state        <= GAP;
            gap_to_fetch <= last_word;
            word_cnt     <= last_word ? '0 : word_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_to_fetch) begin
            state       <= FETCH_REQ;
            mem_read    <= 1'b1;
            mem_address <= {lat_tag, lat_index, word_cnt};
          end else begin
            state          <= WB_REQ;
            mem_write      <= 1'b1;
            mem_address    <= {st_tag, lat_index, word_cnt};
            mem_write_data <= st_data[word_cnt];
          end
        end
        FETCH_REQ: state <= FETCH_WAIT;
        FETCH_WAIT: begin
          if (!mem_busy_wait) begin
            mem_read <= 1'b0;
            if (last_word) begin
              state    <= IDLE;
              word_cnt <= '0;
            end else begin
              state        <= GAP;
              gap_to_fetch <= 1'b1;
              word_cnt     <= word_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
